// File: rtl/uart_prog_loader_pkg.sv
// Shared types and defaults for the UART program loader and its byte receiver.
package uart_prog_loader_pkg;

    // Frame header byte that starts a program load.
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // Loader FSM: CPU held in HALT/DATA/CSUM, released only in RUN.
    typedef enum logic [1:0] {
        HALT = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2,
        RUN  = 2'd3
    } ld_state_t;

    // UART receiver FSM.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver: synchronises rx, checks mid-start-bit, samples
// eight data bits LSB first at bit centres, and reports each byte as either
// valid (stop bit high) or framing error (stop bit low) for one clock.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_ferr
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    logic        rx_s1_q, rx_s2_q;
    rx_state_t   state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // Receiver state, counters and registered byte strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: half a bit to the start-bit centre, then whole bits.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                baud_d = '0;
                if (!rx_s2_q) state_d = RX_START;
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    // Line back high by the start-bit centre: treat as a glitch.
                    state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    valid_d = rx_s2_q;
                    ferr_d  = !rx_s2_q;
                    state_d = RX_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign byte_ferr  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives a header-framed, checksummed image over
// UART, writes it into the CPU RAM, and holds the CPU in reset until a
// verified image is in place.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         PROG_DEPTH   = 16,
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              prog,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        programm_input,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              csum_err,
    output logic              frame_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PROG_DEPTH - 1);

    logic [7:0] rx_byte;
    logic       byte_valid, byte_ferr;

    ld_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic              prog_q, prog_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        pin_q, pin_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              csum_err_q, csum_err_d;
    logic              frame_err_q, frame_err_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_ferr (byte_ferr)
    );

    // Loader state, RAM write port and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HALT;
            cnt_q       <= '0;
            sum_q       <= '0;
            prog_q      <= 1'b0;
            addr_q      <= '0;
            pin_q       <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            csum_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            prog_q      <= prog_d;
            addr_q      <= addr_d;
            pin_q       <= pin_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            csum_err_q  <= csum_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Loader FSM; status outputs are registered from the next state so they
    // change on the same edge as the state itself.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        prog_d      = 1'b0;
        addr_d      = addr_q;
        pin_d       = pin_q;
        done_d      = 1'b0;
        csum_err_d  = csum_err_q;
        frame_err_d = frame_err_q;
        unique case (state_q)
            HALT, RUN: begin
                // Only a clean header starts a load; anything else is ignored.
                if (byte_valid && rx_byte == HDR_BYTE) begin
                    state_d     = DATA;
                    cnt_d       = '0;
                    sum_d       = '0;
                    csum_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            DATA: begin
                if (byte_ferr) begin
                    state_d     = HALT;
                    frame_err_d = 1'b1;
                end else if (byte_valid) begin
                    prog_d = 1'b1;
                    addr_d = cnt_q[ADDR_W-1:0];
                    pin_d  = rx_byte;
                    sum_d  = sum_q + rx_byte;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = CSUM;
                end
            end
            CSUM: begin
                if (byte_ferr) begin
                    state_d     = HALT;
                    frame_err_d = 1'b1;
                end else if (byte_valid) begin
                    if (rx_byte == sum_q) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = HALT;
                        csum_err_d = 1'b1;
                    end
                end
            end
            default: state_d = HALT;
        endcase
        cpu_reset_d = (state_d != RUN);
        busy_d      = (state_d == DATA) || (state_d == CSUM);
    end

    assign prog           = prog_q;
    assign addr           = addr_q;
    assign programm_input = pin_q;
    assign cpu_reset      = cpu_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign csum_err       = csum_err_q;
    assign frame_err      = frame_err_q;

endmodule
